// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
//
// Purpose:
//   Turns the raw A/B pins of a 2-channel quadrature encoder into a one-cycle
//   step pulse plus a direction level for the up/down count stage
//   (step -> ped, up -> uphdnl). Each channel is synchronised and,
//   optionally, debounced. The accepted {A,B} pair is then checked against
//   the Gray sequence.
//
//   Up sequence   : 00 -> 10 -> 11 -> 01 -> 00
//   Down sequence : 00 -> 01 -> 11 -> 10 -> 00
//   Both bits changing in one cycle is illegal. It gives an err pulse.
//
// Parameters:
//   DB_WIDTH  width of each per-channel debounce counter
//   DB_LIMIT  consecutive stable clk cycles before a new level is accepted
//             (1 <= DB_LIMIT < 2**DB_WIDTH)
//   X4_MODE   0 = one step per full detent cycle (on entry to 00)
//             1 = one step on every legal edge
//
// Configuration macro:
//   DEBOUNCE_EN  defined   -> per-channel debounce counters present.
//                              Latency from pin to step is DB_LIMIT+3 edges.
//                undefined -> the synchronised value is accepted directly.
//                              Latency is 3 edges. DB_WIDTH and DB_LIMIT have
//                              no effect.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-high reset
//   a_in  in   raw encoder channel A (asynchronous to clk)
//   b_in  in   raw encoder channel B (asynchronous to clk)
//   step  out  one-cycle pulse per decoded step
//   up    out  direction of the last step (1 = A leads B), holds between steps
//   err   out  one-cycle pulse on an illegal transition (A and B both changed)
//
// Debug:
//   The decoder FSM register is the signal 'state' (ST_INIT / ST_TRACK).
//   Checkers can bind to it.
// ---------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int DB_WIDTH = 16,
  parameter int DB_LIMIT = 50000,
  parameter int X4_MODE  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic up,
  output logic err
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers. Bit 0 is the metastability flop and bit 1 is the
  // synchronised value. Nothing downstream looks at bit 0.
  // -------------------------------------------------------------------------
  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic       a_s;
  logic       b_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a_in};
      b_sync <= {b_sync[0], b_in};
    end
  end

  assign a_s = a_sync[1];
  assign b_s = b_sync[1];

  // -------------------------------------------------------------------------
  // Pipeline-primed flag. The synchronised value only reflects the pins from
  // the second edge after reset. Before that it is the reset 0. INIT must not
  // lock onto that value, or an encoder resting at 11 would report a false
  // error as soon as the real level arrives.
  // -------------------------------------------------------------------------
  logic [1:0] prime_sr;
  logic       primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_sr <= 2'b00;
    end else begin
      prime_sr <= {prime_sr[0], 1'b1};
    end
  end

  assign primed = prime_sr[1];

  // -------------------------------------------------------------------------
  // Accepted levels and INIT-exit condition
  // -------------------------------------------------------------------------
  logic a_acc;
  logic b_acc;
  logic init_done;

`ifdef DEBOUNCE_EN
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_LIMIT - 1);

  logic [DB_WIDTH-1:0] a_cnt;
  logic [DB_WIDTH-1:0] b_cnt;
  logic [DB_WIDTH-1:0] stab_cnt;
  logic                stable;

  // Per-channel debounce. The counter runs only while synced != accepted and
  // clears when they agree. It also clears when a new level is taken. So it
  // never passes DB_LAST and needs no explicit saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= '0;
      a_acc <= 1'b0;
    end else if (a_s == a_acc) begin
      a_cnt <= '0;
    end else if (a_cnt == DB_LAST) begin
      a_acc <= a_s;
      a_cnt <= '0;
    end else begin
      a_cnt <= a_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cnt <= '0;
      b_acc <= 1'b0;
    end else if (b_s == b_acc) begin
      b_cnt <= '0;
    end else if (b_cnt == DB_LAST) begin
      b_acc <= b_s;
      b_cnt <= '0;
    end else begin
      b_cnt <= b_cnt + 1'b1;
    end
  end

  // Both channels agree with their accepted level. This holds only once the
  // synchroniser carries real pin samples.
  assign stable = primed && (a_s == a_acc) && (b_s == b_acc);

  // Counts consecutive stable cycles while in INIT. Any disagreement
  // restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (state != ST_INIT || !stable) begin
      stab_cnt <= '0;
    end else if (stab_cnt != DB_LAST) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Exit on the DB_LIMIT-th consecutive stable cycle.
  assign init_done = stable && (stab_cnt == DB_LAST);
`else
  // No filtering. The synchronised value is the accepted value. INIT leaves
  // on the first cycle the synchroniser holds a real sample.
  logic unused_db_params;

  assign a_acc            = a_s;
  assign b_acc            = b_s;
  assign init_done        = primed;
  assign unused_db_params = ^{DB_WIDTH[0], DB_LIMIT[0]};
`endif

  // -------------------------------------------------------------------------
  // Gray-sequence tracker
  // -------------------------------------------------------------------------
  logic [1:0] cur_ab;
  logic [1:0] prev_ab;
  logic [1:0] prev_nxt;
  logic [1:0] diff_ab;
  logic       dir_up;
  logic       step_nxt;
  logic       err_nxt;
  logic       up_nxt;

  assign cur_ab  = {a_acc, b_acc};
  assign diff_ab = cur_ab ^ prev_ab;

  // For a single-bit change, the move is "up" exactly when the new A differs
  // from the old B. This covers 00->10, 10->11, 11->01 and 01->00.
  assign dir_up = prev_ab[0] ^ cur_ab[1];

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_ab;
    step_nxt  = 1'b0;
    err_nxt   = 1'b0;
    up_nxt    = up;
    case (state)
      ST_INIT: begin
        // Take the resting position as the reference. Emit no step or err.
        if (init_done) begin
          prev_nxt  = cur_ab;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        prev_nxt = cur_ab;
        if (diff_ab == 2'b11) begin
          err_nxt = 1'b1;
        end else if (diff_ab != 2'b00) begin
          // In X1 mode, only the edge that lands on 00 completes a detent.
          if (X4_MODE != 0 || cur_ab == 2'b00) begin
            step_nxt = 1'b1;
            up_nxt   = dir_up;
          end
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      prev_ab <= 2'b00;
      step    <= 1'b0;
      err     <= 1'b0;
      up      <= 1'b1;
    end else begin
      state   <= state_nxt;
      prev_ab <= prev_nxt;
      step    <= step_nxt;
      err     <= err_nxt;
      up      <= up_nxt;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Testbench for quad_step_decoder. The main instance runs with X4_MODE=1 and
// DB_LIMIT=4. A second instance runs with X4_MODE=0; its step pulses are
// counted per sequence.
//
// Each stimulus call pushes its expected output event onto exp_q. The entry
// holds the expected cycle, err, step and up. The monitor runs on the falling
// edge. It pops and compares an entry whenever the main DUT shows a step or
// an err pulse.
// ---------------------------------------------------------------------------
module tb_quad_step_decoder;

  localparam int DB_WIDTH = 8;
  localparam int DB_LIMIT = 4;

`ifdef DEBOUNCE_EN
  localparam int LAT      = DB_LIMIT + 3;
  localparam int MIN_HOLD = DB_LIMIT;
  localparam int RST_WAIT = 4;
`else
  localparam int LAT      = 3;
  localparam int MIN_HOLD = 1;
  localparam int RST_WAIT = 2;
`endif

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic a_in = 1'b1;
  logic b_in = 1'b1;
  int   cyc  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic step;
  logic up;
  logic err;
  logic step0;
  logic up0;
  logic err0;

  quad_step_decoder #(
    .DB_WIDTH(DB_WIDTH),
    .DB_LIMIT(DB_LIMIT),
    .X4_MODE (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a_in(a_in),
    .b_in(b_in),
    .step(step),
    .up  (up),
    .err (err)
  );

  quad_step_decoder #(
    .DB_WIDTH(DB_WIDTH),
    .DB_LIMIT(DB_LIMIT),
    .X4_MODE (0)
  ) dut_x1 (
    .clk (clk),
    .rst (rst),
    .a_in(a_in),
    .b_in(b_in),
    .step(step0),
    .up  (up0),
    .err (err0)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [34:0] exp_q[$];
  logic [34:0] got_ev;
  logic [34:0] want_ev;
  logic [1:0]  m_prev;
  logic        m_up;
  int          x1_steps = 0;
  int          x1_errs  = 0;
  int          base;

  // Successor of each position on the up sequence.
  function automatic logic [1:0] next_up(input logic [1:0] p);
    case (p)
      2'b00:   next_up = 2'b10;
      2'b10:   next_up = 2'b11;
      2'b11:   next_up = 2'b01;
      default: next_up = 2'b00;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Drive {a,b} at a falling edge and hold it for 'hold' cycles. If the hold
  // is long enough to be accepted, update the model and queue the expected
  // step or err event.
  task automatic set_ab(input logic a, input logic b, input int hold);
    logic [1:0] cur;
    cur  = {a, b};
    a_in = a;
    b_in = b;
    if (hold >= MIN_HOLD && cur != m_prev) begin
      if ((cur ^ m_prev) == 2'b11) begin
        exp_q.push_back({32'(cyc + LAT), 1'b1, 1'b0, m_up});
      end else begin
        m_up = (cur == next_up(m_prev));
        exp_q.push_back({32'(cyc + LAT), 1'b0, 1'b1, m_up});
      end
      m_prev = cur;
    end
    repeat (hold) @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && (step || err)) begin
      got_ev = {32'(cyc), err, step, up};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: cyc=%0d err=%b step=%b up=%b, required no pulse",
                 cyc, err, step, up);
      end else begin
        want_ev = exp_q.pop_front();
        if (got_ev !== want_ev) begin
          failures++;
          $display("FAIL pulse: got cyc=%0d err=%b step=%b up=%b required cyc=%0d err=%b step=%b up=%b",
                   got_ev[34:3], got_ev[2], got_ev[1], got_ev[0],
                   want_ev[34:3], want_ev[2], want_ev[1], want_ev[0]);
        end
      end
    end
    if (!rst && step0) x1_steps++;
    if (!rst && err0) x1_errs++;
  end

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    m_prev = 2'b11;
    m_up   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_err", int'(err), 0);
    check("reset_up", int'(up), 1);
    check("reset_x1_up", int'(up0), 1);

    // Test 1: the encoder rests at 11 through reset. INIT absorbs it.
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("init_up", int'(up), 1);
    check("init_x1_errs", x1_errs, 0);

    // Move to 00 along the up sequence.
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);

    // Test 2: one full up cycle.
    base = x1_steps;
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    check("up_seq_up", int'(up), 1);
    check("up_seq_x1_steps", x1_steps - base, 1);
    check("up_seq_x1_up", int'(up0), 1);

    // Test 3: one full down cycle.
    base = x1_steps;
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b0, 1'b0, 10);
    check("down_seq_up", int'(up), 0);
    check("down_seq_x1_steps", x1_steps - base, 1);
    check("down_seq_x1_up", int'(up0), 0);

    // Test 4: short glitches on a resting 00.
    for (int i = 0; i < 3; i++) begin
      set_ab(1'b1, 1'b0, 2);
      set_ab(1'b0, 1'b0, 10);
    end
    set_ab(1'b0, 1'b1, 2);
    set_ab(1'b0, 1'b0, 10);

    // Test 5: illegal jump 00->11, then normal steps.
    base = x1_errs;
    set_ab(1'b1, 1'b1, 10);
    check("jump_x1_errs", x1_errs - base, 1);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    // A down step leaves up=0, so the reset-to-1 below can be observed.
    set_ab(1'b0, 1'b1, 10);
    check("pre_reset_up", int'(up), 0);

    // Test 6: reset while a change on A is still being filtered.
    a_in = 1'b1;
    repeat (RST_WAIT) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_step", int'(step), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_up", int'(up), 1);
    m_prev = 2'b11;
    m_up   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    set_ab(1'b0, 1'b1, 10);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
